uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- UART transmit path for the UMI UART controller: 16-entry transmit holding FIFO plus a serializer shift-register FSM that drives the serial output line.
- Line-control settings are the 16550 LCR format: word length, parity, stop bits and break.
- Bit timing comes from the shared 16x baud `enable` tick produced by the baud divider.
- Serves as the transmit-side counterpart of the receiver FIFO in the same controller.

Parameters:
FIFO_DEPTH, 16, number of TX FIFO entries
FIFO_POINTER_W, 4, FIFO pointer width, log2(FIFO_DEPTH)
FIFO_COUNTER_W, 5, FIFO occupancy counter width, log2(FIFO_DEPTH)+1

Ports:
clk  input  1  core clock
nreset  input  1  reset; synchronous, active-low
enable  input  1  16x baud tick, one clk cycle wide
lcr  input  8  line control: [1:0] word length (00=5..11=8), [2] stop select, [3] parity enable, [4] even parity, [5] stick parity, [6] break
data_in  input  8  byte written to THR
push  input  1  write strobe, active high
fifo_reset  input  1  clears TX FIFO, active high
stx_o  output  1  serial output
count  output  FIFO_COUNTER_W  FIFO occupancy
thre  output  1  FIFO empty (count==0)
temt  output  1  FIFO empty and FSM in IDLE

Behaviour:
- Reset is synchronous on clk with nreset=0. Reset values: FIFO pointers=0, count=0, FSM=IDLE, stx_o=1, thre=1, temt=1.
- FIFO storage is circular; pointers wrap at DEPTH-1 -> 0.
- Push:
  - Writes data_in at top when count<DEPTH, or when an internal pop happens in the same cycle.
  - A push while full with no pop is dropped silently; count and contents are unchanged.
- fifo_reset:
  - Zeroes pointers and count; has priority over push.
  - Does not abort a frame already loaded in the shifter.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Bit counting: a 4-bit tick counter advances only on `enable`. Each bit lasts 16 ticks, except as noted for STOP.
- IDLE:
  - stx=1.
  - On an enable tick with count>0: pop FIFO head into the shift register, decrement count (a simultaneous push leaves count unchanged), and latch lcr[5:0] into the frame config.
  - Go to START; stx=0 from the next cycle.
- START: 16 ticks at 0, then go to DATA.
- DATA:
  - LSB first; one bit per 16 ticks.
  - Bit count is 5+lcr[1:0] from the latched config.
  - Then go to PARITY if parity is enabled, else STOP.
- PARITY bit value, from the latched config:
  - stick=1: bit = ~even.
  - stick=0, even=1: bit = XOR of the transmitted data bits.
  - stick=0, even=0: bit = inverted XOR of the transmitted data bits.
  - Bits above the word length are excluded from the XOR.
- STOP:
  - stx=1.
  - Length with lcr[2]=0: 16 ticks.
  - Length with lcr[2]=1 and 5-bit word: 24 ticks.
  - Length with lcr[2]=1 and other word lengths: 32 ticks.
  - Then go to IDLE.
  - Back-to-back frames: when the FIFO is non-empty, the next pop occurs on the first enable tick in IDLE.
- Break:
  - stx_o = stx_reg & ~lcr[6], using live lcr, not the latched copy.
  - Break does not stall the FSM or the FIFO.
- Enable gating: with enable held low, the FSM and tick counter freeze. Push still works.
- Reset mid-frame: the frame is abandoned and stx_o returns to 1 in the cycle after nreset is sampled low.

Test Plan:
- 8N1 (lcr=0x03), enable tied high, push 0x55 -> stx_o holds each level for 16 cycles: 0 (start), then 1,0,1,0,1,0,1,0, then 1 (stop). Frame = 160 ticks; temt=1 afterwards.
- 5E1.5 (lcr=0x1C), push 0x13 -> data bits 1,1,0,0,1, parity=1, stop high for 24 ticks. Repeat with stick parity (lcr=0x3C) -> parity=0.
- Enable stalled, push 17 bytes 0x00..0x10 -> count=16; 0x10 dropped. Release enable -> 16 frames 0x00..0x0F in order, back-to-back with no idle gap; thre rises at the last pop.
- FIFO full while the FSM pops on an enable tick, with push in the same cycle -> push accepted, count stays 16, and the new byte is the last one transmitted.
- Break: lcr[6]=1 set mid-frame -> stx_o=0 immediately. Clear lcr[6] -> frame resumes at the correct bit position.
- nreset low mid-DATA with 3 bytes queued -> after the next edge: stx_o=1, count=0, thre=1, temt=1, FSM IDLE. fifo_reset mid-frame -> current frame completes, queued bytes discarded.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmit path: 16-entry holding FIFO feeding a start/data/parity/stop serializer.
// Bits are paced by the shared 16x baud enable tick. Break forces the line low using live LCR.
module uart_transmitter #(
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned FIFO_POINTER_W = 4,
  parameter int unsigned FIFO_COUNTER_W = 5
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      enable,
  input  logic [7:0]                lcr,
  input  logic [7:0]                data_in,
  input  logic                      push,
  input  logic                      fifo_reset,
  output logic                      stx_o,
  output logic [FIFO_COUNTER_W-1:0] count,
  output logic                      thre,
  output logic                      temt
);
  localparam int unsigned TICK_W = 4;
  localparam int unsigned BIT_W  = 3;
  localparam logic [FIFO_POINTER_W-1:0] PTR_LAST = FIFO_POINTER_W'(FIFO_DEPTH - 1);
  localparam logic [FIFO_COUNTER_W-1:0] CNT_FULL = FIFO_COUNTER_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [7:0]                r_mem [FIFO_DEPTH];
  logic [FIFO_POINTER_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_COUNTER_W-1:0] r_count;

  state_t            r_state, w_state_nxt;
  logic [TICK_W-1:0] r_tick, w_tick_nxt;
  logic [BIT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic [5:0]        r_cfg, w_cfg_nxt;
  logic              r_par, w_par_nxt;
  logic              r_stx, w_stx_nxt;

  logic             w_pop, w_push_ok;
  logic             w_tick_last, w_par_bit, w_stop_done;
  logic [BIT_W-1:0] w_last_bit;
  logic             w_unused_lcr7;

  function automatic logic [FIFO_POINTER_W-1:0] ptr_inc(input logic [FIFO_POINTER_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + FIFO_POINTER_W'(1);
  endfunction

  // Frame helpers derived from the configuration latched at pop time.
  assign w_tick_last = (r_tick == '1);
  assign w_last_bit  = BIT_W'(4) + BIT_W'(r_cfg[1:0]);
  assign w_par_bit   = r_cfg[5] ? ~r_cfg[4] : (r_cfg[4] ? r_par : ~r_par);
  assign w_stop_done = !r_cfg[2] ? w_tick_last :
                       ((r_bit_cnt == BIT_W'(1)) &&
                        (r_tick == ((r_cfg[1:0] == 2'b00) ? TICK_W'(7) : TICK_W'(15))));

  // A full FIFO still accepts a write when the serializer pops in the same cycle.
  assign w_push_ok = nreset && push && !fifo_reset && ((r_count < CNT_FULL) || w_pop);

  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_cfg_nxt     = r_cfg;
    w_par_nxt     = r_par;
    w_stx_nxt     = r_stx;
    w_pop         = 1'b0;
    if (enable) begin
      w_tick_nxt = r_tick + TICK_W'(1);
      unique case (r_state)
        S_IDLE: begin
          w_tick_nxt = '0;
          w_stx_nxt  = 1'b1;
          if (r_count != '0) begin
            w_pop       = 1'b1;
            w_shift_nxt = r_mem[r_rd_ptr];
            w_cfg_nxt   = lcr[5:0];
            w_par_nxt   = 1'b0;
            w_stx_nxt   = 1'b0;
            w_state_nxt = S_START;
          end
        end
        S_START: begin
          if (w_tick_last) begin
            w_state_nxt   = S_DATA;
            w_bit_cnt_nxt = '0;
            w_stx_nxt     = r_shift[0];
            w_par_nxt     = r_par ^ r_shift[0];
            w_shift_nxt   = {1'b0, r_shift[7:1]};
          end
        end
        S_DATA: begin
          if (w_tick_last) begin
            if (r_bit_cnt == w_last_bit) begin
              w_bit_cnt_nxt = '0;
              if (r_cfg[3]) begin
                w_state_nxt = S_PARITY;
                w_stx_nxt   = w_par_bit;
              end else begin
                w_state_nxt = S_STOP;
                w_stx_nxt   = 1'b1;
              end
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
              w_stx_nxt     = r_shift[0];
              w_par_nxt     = r_par ^ r_shift[0];
              w_shift_nxt   = {1'b0, r_shift[7:1]};
            end
          end
        end
        S_PARITY: begin
          if (w_tick_last) begin
            w_state_nxt   = S_STOP;
            w_bit_cnt_nxt = '0;
            w_stx_nxt     = 1'b1;
          end
        end
        S_STOP: begin
          // bit counter counts whole 16-tick stop periods for the 1.5/2 stop cases
          if (w_stop_done) begin
            w_state_nxt   = S_IDLE;
            w_bit_cnt_nxt = '0;
            w_stx_nxt     = 1'b1;
          end else if (w_tick_last) begin
            w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_cfg     <= '0;
      r_par     <= 1'b0;
      r_stx     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_tick    <= w_tick_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_cfg     <= w_cfg_nxt;
      r_par     <= w_par_nxt;
      r_stx     <= w_stx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= data_in;
  end

  // fifo_reset clears occupancy only; a frame already in the shifter keeps going.
  always_ff @(posedge clk) begin
    if (!nreset || fifo_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)     r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push_ok && !w_pop)      r_count <= r_count + FIFO_COUNTER_W'(1);
      else if (!w_push_ok && w_pop) r_count <= r_count - FIFO_COUNTER_W'(1);
    end
  end

  assign stx_o         = r_stx & ~lcr[6];
  assign count         = r_count;
  assign thre          = (r_count == '0);
  assign temt          = thre && (r_state == S_IDLE);
  assign w_unused_lcr7 = lcr[7];

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: directed scenarios plus random traffic, checked every cycle
// against a queue model that expands each popped byte into its per-tick line levels.
module tb_uart_transmitter;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       nreset, enable, push, fifo_reset;
  logic [7:0] lcr, data_in;
  logic       stx_o, thre, temt;
  logic [4:0] count;

  int n_total = 0;
  int n_bad   = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  uart_transmitter dut (
    .clk(clk), .nreset(nreset), .enable(enable), .lcr(lcr), .data_in(data_in),
    .push(push), .fifo_reset(fifo_reset), .stx_o(stx_o), .count(count),
    .thre(thre), .temt(temt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO contents and remaining line levels of the frame on the wire.
  logic [7:0] mq[$];
  bit         wq[$];
  bit         m_stx = 1'b1;

  function automatic void build_frame(input logic [7:0] d, input logic [5:0] c);
    int n    = 5 + int'(c[1:0]);
    int stop = c[2] ? ((n == 5) ? 24 : 32) : 16;
    bit par  = 1'b0;
    bit pb;
    repeat (16) wq.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      repeat (16) wq.push_back(d[i]);
      par ^= d[i];
    end
    if (c[3]) begin
      pb = c[5] ? ~c[4] : (c[4] ? par : ~par);
      repeat (16) wq.push_back(pb);
    end
    repeat (stop + 1) wq.push_back(1'b1);
  endfunction

  always @(posedge clk) begin
    if (!nreset) begin
      mq.delete();
      wq.delete();
      m_stx = 1'b1;
    end else begin
      if (enable) begin
        if (wq.size() == 0 && mq.size() != 0) build_frame(mq.pop_front(), lcr[5:0]);
        if (wq.size() != 0) m_stx = wq.pop_front();
      end
      if (fifo_reset) mq.delete();
      else if (push && mq.size() < DEPTH) mq.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("stx_o", 32'(stx_o), 32'(m_stx & ~lcr[6]));
      check("count", 32'(count), 32'(mq.size()));
      check("thre",  32'(thre),  32'(mq.size() == 0));
      check("temt",  32'(temt),  32'(mq.size() == 0 && wq.size() == 0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push_byte(input logic [7:0] d);
    push = 1'b1;
    data_in = d;
    step();
    push = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (temt !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    check("idle_timeout", 32'(temt), 32'd1);
  endtask

  initial begin
    nreset = 1'b0; enable = 1'b0; push = 1'b0; fifo_reset = 1'b0;
    lcr = 8'h03; data_in = 8'h00;
    run(2);
    check("rst_stx",   32'(stx_o), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_thre",  32'(thre),  32'd1);
    check("rst_temt",  32'(temt),  32'd1);
    nreset = 1'b1;
    chk_on = 1'b1;
    step();

    // 8N1 alternating pattern
    enable = 1'b1;
    lcr = 8'h03;
    push_byte(8'h55);
    wait_idle(400);

    // 5E1.5, then stick parity
    lcr = 8'h1C;
    push_byte(8'h13);
    wait_idle(400);
    lcr = 8'h3C;
    push_byte(8'h13);
    wait_idle(400);

    // fill while stalled; the 17th byte is dropped
    enable = 1'b0;
    lcr = 8'h03;
    for (int i = 0; i < 17; i++) push_byte(8'(i));
    check("full_count", 32'(count), 32'd16);
    enable = 1'b1;
    wait_idle(4000);

    // full FIFO: pop and push in the same cycle
    enable = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
    enable = 1'b1;
    push_byte(8'hA5);
    check("full_pop_push", 32'(count), 32'd16);
    wait_idle(4000);

    // break mid-frame, then resume
    lcr = 8'h03;
    push_byte(8'h0F);
    run(40);
    lcr = 8'h43;
    #1;
    check("break_low", 32'(stx_o), 32'd0);
    run(20);
    lcr = 8'h03;
    wait_idle(400);

    // reset in DATA with 3 bytes queued
    for (int i = 0; i < 4; i++) push_byte(8'(8'hC0 + i));
    run(40);
    check("pre_rst_count", 32'(count), 32'd3);
    nreset = 1'b0;
    step();
    check("mid_rst_stx",   32'(stx_o), 32'd1);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_thre",  32'(thre),  32'd1);
    check("mid_rst_temt",  32'(temt),  32'd1);
    nreset = 1'b1;
    step();

    // fifo_reset mid-frame: current frame completes, queue discarded
    for (int i = 0; i < 4; i++) push_byte(8'(8'h90 + i));
    run(40);
    fifo_reset = 1'b1;
    step();
    fifo_reset = 1'b0;
    check("frst_count", 32'(count), 32'd0);
    check("frst_busy",  32'(temt),  32'd0);
    wait_idle(400);

    // random traffic
    for (int i = 0; i < 9000; i++) begin
      enable     = ($urandom_range(0, 3) != 0);
      push       = ($urandom_range(0, 9) == 0);
      data_in    = 8'($urandom);
      fifo_reset = ($urandom_range(0, 599) == 0);
      nreset     = ($urandom_range(0, 2999) != 0);
      if ($urandom_range(0, 63) == 0) begin
        lcr = 8'($urandom) & 8'hBF;
        if ($urandom_range(0, 7) == 0) lcr[6] = 1'b1;
      end
      step();
    end
    push = 1'b0; fifo_reset = 1'b0; nreset = 1'b1; enable = 1'b1;
    lcr[6] = 1'b0;
    step();
    wait_idle(6000);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
